rijndael_round_ctrl: RTL and testbench

// - Round sequencer for one iterative Rijndael encryption core (NB, NK generic).
// - Accepts a block/key job via valid/ready, then reloads and steps the key schedule.
// - Drives round index and first/last-round strobes to the round datapath.
// - Presents the result via a valid/ready output handshake.

---
 rtl/rijndael_round_ctrl.sv | 140 ++++++++++++++
 tb/tb_rijndael_round_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rijndael_round_ctrl.sv
// rtl/rijndael_round_ctrl.sv - round sequencer for an iterative Rijndael encryption core.
// Optional abort input enabled by defining RIJNDAEL_CTRL_ABORT_EN.
module rijndael_round_ctrl #(
  parameter  int NB = 4,
  parameter  int NK = 4,
  localparam int NR = ((NB > NK) ? NB : NK) + 6,
  localparam int RW = $clog2(NR + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
`ifdef RIJNDAEL_CTRL_ABORT_EN
  input  logic          abort_i,
`endif
  output logic          ks_load_o,
  output logic          ks_enable_o,
  output logic          state_en_o,
  output logic          first_o,
  output logic          last_o,
  output logic [RW-1:0] round_o,
  output logic          busy_o
);

  if (NB < 4 || NB > 8 || NK < 4 || NK > 8) begin : g_bad_params
    $error("rijndael_round_ctrl: NB and NK must lie in 4..8");
  end

  localparam logic [RW-1:0] NR_W = RW'(NR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic          abort_w;

`ifdef RIJNDAEL_CTRL_ABORT_EN
  assign abort_w = abort_i && (state_q != S_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    ks_load_o   = 1'b0;
    ks_enable_o = 1'b0;
    state_en_o  = 1'b0;
    first_o     = 1'b0;
    last_o      = 1'b0;
    busy_o      = 1'b0;
    round_o     = '0;

    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        round_d    = '0;
        if (in_valid_i) state_d = S_INIT;
      end
      S_INIT: begin
        ks_load_o = 1'b1;
        busy_o    = 1'b1;
        round_d   = '0;
        state_d   = S_ROUND;
      end
      S_ROUND: begin
        state_en_o = 1'b1;
        busy_o     = 1'b1;
        round_o    = round_q;
        first_o    = (round_q == '0);
        last_o     = (round_q == NR_W);
        if (round_q < NR_W) begin
          ks_enable_o = 1'b1;
          round_d     = round_q + RW'(1);
        end else begin
          round_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid_o = 1'b1;
        round_d     = '0;
        // Releasing the result and taking a new job share one edge.
        if (out_ready_i) begin
          in_ready_o = 1'b1;
          state_d    = in_valid_i ? S_INIT : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
      end
    endcase

    if (abort_w) begin
      state_d     = S_IDLE;
      round_d     = '0;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      ks_load_o   = 1'b0;
      ks_enable_o = 1'b0;
      state_en_o  = 1'b0;
      first_o     = 1'b0;
      last_o      = 1'b0;
    end

    // Reset masks every output combinationally, not just from the next edge.
    if (rst_i) begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      ks_load_o   = 1'b0;
      ks_enable_o = 1'b0;
      state_en_o  = 1'b0;
      first_o     = 1'b0;
      last_o      = 1'b0;
      busy_o      = 1'b0;
      round_o     = '0;
    end
  end

endmodule

// File: tb/tb_rijndael_round_ctrl.sv
// tb/tb_rijndael_round_ctrl.sv - scoreboard bench for rijndael_round_ctrl (NK=4 and NK=8 instances).
module tb_rijndael_round_ctrl;

  typedef struct {
    int lat;
    int ks_n;
  } exp_t;

  logic       clk;
  logic       rst       [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic       abort     [2];
  logic       ks_load   [2];
  logic       ks_en     [2];
  logic       state_en  [2];
  logic       first     [2];
  logic       last      [2];
  logic       busy      [2];
  logic [3:0] round_s   [2];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bits: in_ready, out_valid, ks_load, ks_en, state_en, first, last, busy, round[3:0]
  function automatic logic [11:0] exp_vec(input int c, input int nr, input logic ordy);
    logic [11:0] e;
    int r;
    e = '0;
    if (c == 1) begin
      e[9] = 1'b1;
      e[4] = 1'b1;
    end else if (c >= 2 && c <= nr + 2) begin
      r      = c - 2;
      e[7]   = 1'b1;
      e[6]   = (r == 0);
      e[5]   = (r == nr);
      e[8]   = (r < nr);
      e[4]   = 1'b1;
      e[3:0] = 4'(r);
    end else if (c >= nr + 3) begin
      e[10] = 1'b1;
      e[11] = ordy;
    end
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int NRG = (g == 0) ? 10 : 14;

    rijndael_round_ctrl #(.NB(4), .NK((g == 0) ? 4 : 8)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst[g]),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
`ifdef RIJNDAEL_CTRL_ABORT_EN
      .abort_i     (abort[g]),
`endif
      .ks_load_o   (ks_load[g]),
      .ks_enable_o (ks_en[g]),
      .state_en_o  (state_en[g]),
      .first_o     (first[g]),
      .last_o      (last[g]),
      .round_o     (round_s[g]),
      .busy_o      (busy[g])
    );

    exp_t        q[$];
    exp_t        r;
    int          cyc;
    int          ks_cnt;
    bit          active = 1'b0;
    bit          seen;
    logic [11:0] v;

    always @(negedge clk) begin
      v = {in_ready[g], out_valid[g], ks_load[g], ks_en[g], state_en[g],
           first[g], last[g], busy[g], round_s[g]};
      if (rst[g]) begin
        check($sformatf("u%0d_reset", g), 32'(v), 32'h0);
        active = 1'b0;
        q.delete();
      end else if (active && abort[g]) begin
        check($sformatf("u%0d_abort", g), 32'(v & 12'hF80), 32'h0);
        active = 1'b0;
        q.delete();
      end else begin
        if (active) begin
          cyc++;
          check($sformatf("u%0d_seq_c%0d", g, cyc), 32'(v), 32'(exp_vec(cyc, NRG, out_ready[g])));
          if (ks_en[g]) ks_cnt++;
          if (out_valid[g] && !seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
              check($sformatf("u%0d_sb_unexpected", g), 32'd1, 32'd0);
            end else begin
              r = q.pop_front();
              check($sformatf("u%0d_latency", g), 32'(cyc), 32'(r.lat));
              check($sformatf("u%0d_ks_pulses", g), 32'(ks_cnt), 32'(r.ks_n));
            end
          end
          if (out_valid[g] && out_ready[g]) active = 1'b0;
        end else begin
          check($sformatf("u%0d_idle", g), 32'(v), 32'h800);
        end
        if (in_valid[g] && in_ready[g]) begin
          active = 1'b1;
          cyc    = 0;
          ks_cnt = 0;
          seen   = 1'b0;
          q.push_back('{lat: NRG + 3, ks_n: NRG});
        end
      end
    end
  end

  task automatic run_job(input int g);
    int n;
    n = 0;
    in_valid[g] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready[g] && n < 50);
    if (n >= 50) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid[g] && out_ready[g]) && n < 60);
    if (n >= 60) check("done_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_round(input int g, input logic [3:0] rv);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (round_s[g] != rv && n < 40);
    if (n >= 40) check("round_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b1;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      abort[i]     = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Single jobs on both geometries
    run_job(0);
    wait_done(0);
    run_job(1);
    wait_done(1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure in DONE, then back-to-back accept
    out_ready[0] = 1'b0;
    run_job(0);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid[0] && n < 40);
      if (n >= 40) check("bp_timeout", 32'd1, 32'd0);
    end
    @(posedge clk);
    #1 in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid[0]), 32'd1);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(negedge clk);
    check("b2b_ks_load", 32'(ks_load[0]), 32'd1);
    wait_done(0);

    // Reset during round 5, then a fresh job
    run_job(0);
    wait_round(0, 4'd4);
    @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_strobes", 32'({ks_load[0], ks_en[0], state_en[0], out_valid[0]}), 32'd0);
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    run_job(0);
    wait_done(0);

`ifdef RIJNDAEL_CTRL_ABORT_EN
    run_job(0);
    wait_round(0, 4'd2);
    @(posedge clk);
    #1 abort[0] = 1'b1;
    @(negedge clk);
    check("abort_ks_en", 32'(ks_en[0]), 32'd0);
    check("abort_out_valid", 32'(out_valid[0]), 32'd0);
    @(posedge clk);
    #1 abort[0] = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready[0]), 32'd1);
    repeat (15) @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_empty_u0", 32'(g_dut[0].q.size()), 32'd0);
    check("sb_empty_u1", 32'(g_dut[1].q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
